// File: rtl/cxu_link_buffer_pkg.sv
// cxu_link_buffer_pkg
//   Shared types and helpers for the CXU-LI link buffer slice.
//   - CXU_STATUS_W / cxu_status_e : response status field
//   - skid_state_e                : occupancy of the 2-entry request skid buffer
//   - field_w()                   : width of a field declared as W bits, with W == 0 => 1 bit
package cxu_link_buffer_pkg;

   localparam int unsigned CXU_STATUS_W = 3;

   typedef enum logic [CXU_STATUS_W-1:0] {
      CxuStatusOk   = 3'd0,
      CxuStatusErr  = 3'd1,
      CxuStatusBusy = 3'd2
   } cxu_status_e;

   typedef enum logic [1:0] {
      StEmpty = 2'd0,
      StOne   = 2'd1,
      StTwo   = 2'd2
   } skid_state_e;

   // A zero-width field is carried as a single tied bit so ports never vanish.
   function automatic int unsigned field_w(input int unsigned w);
      return (w == 0) ? 32'd1 : w;
   endfunction

endpackage

// File: rtl/cxu_link_buffer_if.sv
// cxu_link_buffer_if
//   One CXU-LI link: request channel (valid/ready + cxu/state/func/insn/data0/data1 payload)
//   and response channel (valid/ready + status/data).
//   master : issues requests, accepts responses (mux side of a link, or the buffer towards a CXU)
//   slave  : accepts requests, issues responses
interface cxu_link_buffer_if #(
   parameter int unsigned CXU_N_CXUS    = 4,
   parameter int unsigned CXU_N_STATES  = 0,
   parameter int unsigned CXU_FUNC_ID_W = 3,
   parameter int unsigned CXU_INSN_W    = 0,
   parameter int unsigned CXU_DATA_W    = 32
);
   import cxu_link_buffer_pkg::*;

   localparam int unsigned ID_W    = field_w($clog2(CXU_N_CXUS));
   localparam int unsigned STATE_W = field_w($clog2(CXU_N_STATES));
   localparam int unsigned FUNC_W  = field_w(CXU_FUNC_ID_W);
   localparam int unsigned INSN_W  = field_w(CXU_INSN_W);
   localparam int unsigned DATA_W  = field_w(CXU_DATA_W);

   logic                    req_valid;
   logic                    req_ready;
   logic [ID_W-1:0]         req_cxu;
   logic [STATE_W-1:0]      req_state;
   logic [FUNC_W-1:0]       req_func;
   logic [INSN_W-1:0]       req_insn;
   logic [DATA_W-1:0]       req_data0;
   logic [DATA_W-1:0]       req_data1;
   logic                    resp_valid;
   logic                    resp_ready;
   logic [CXU_STATUS_W-1:0] resp_status;
   logic [DATA_W-1:0]       resp_data;

   modport master (
      output req_valid, req_cxu, req_state, req_func, req_insn, req_data0, req_data1, resp_ready,
      input  req_ready, resp_valid, resp_status, resp_data
   );

   modport slave (
      input  req_valid, req_cxu, req_state, req_func, req_insn, req_data0, req_data1, resp_ready,
      output req_ready, resp_valid, resp_status, resp_data
   );

endinterface

// File: rtl/cxu_link_buffer_resp_fifo.sv
// cxu_link_buffer_resp_fifo
//   Response FIFO, DEPTH entries (power of two, >= 2) of W bits.
//   clk, rst_n   : clock, async active-low reset (empties the FIFO, clears storage)
//   push, wdata  : write; accepted when not full, or when full and popping in the same cycle
//   pop, rdata   : read head; pop ignored when empty; rdata valid while !empty
//   full, empty  : occupancy flags
//   count        : number of stored entries, 0..DEPTH
module cxu_link_buffer_resp_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = 35
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [W-1:0]             wdata,
   input  logic                     pop,
   output logic [W-1:0]             rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [DEPTH-1:0][W-1:0] mem_q;
   logic [AW-1:0]           wptr_q;
   logic [AW-1:0]           rptr_q;
   logic [AW:0]             count_q;
   logic                    do_push;
   logic                    do_pop;

   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q   <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) begin
            mem_q[wptr_q] <= wdata;
            wptr_q        <= wptr_q + AW'(1);
         end
         if (do_pop) begin
            rptr_q <= rptr_q + AW'(1);
         end
         if (do_push && !do_pop) begin
            count_q <= count_q + (AW+1)'(1);
         end else if (!do_push && do_pop) begin
            count_q <= count_q - (AW+1)'(1);
         end
      end
   end

   assign full  = (count_q == (AW+1)'(DEPTH));
   assign empty = (count_q == '0);
   assign rdata = mem_q[rptr_q];
   assign count = count_q;

endmodule

// File: rtl/cxu_link_buffer.sv
// cxu_link_buffer
//   Registered CXU-LI link stage between a CXU mux target port and one CXU.
//   Requests pass through a 2-entry skid buffer (registered ready, full throughput); responses
//   are absorbed by a FIFO. A credit gate only launches a request when a response slot is
//   guaranteed, so the CXU never sees back-pressure on a legal response.
//   clk, rst_n : clock, async active-low reset (drops all buffered requests/responses)
//   clk_en     : 0 freezes every register; handshakes in such cycles are not counted
//   i_link     : slave side facing the mux (i_req_* in, i_resp_* out)
//   t_link     : master side facing the CXU (t_req_* out, t_resp_* in)
module cxu_link_buffer #(
   parameter int unsigned CXU_N_CXUS    = 4,
   parameter int unsigned CXU_N_STATES  = 0,
   parameter int unsigned CXU_FUNC_ID_W = 3,
   parameter int unsigned CXU_INSN_W    = 0,
   parameter int unsigned CXU_DATA_W    = 32,
   parameter int unsigned N_REQS        = 16,
   parameter int unsigned RESP_DEPTH    = 4
) (
   input logic               clk,
   input logic               rst_n,
   input logic               clk_en,
   cxu_link_buffer_if.slave  i_link,
   cxu_link_buffer_if.master t_link
);
   import cxu_link_buffer_pkg::*;

   localparam int unsigned ID_W    = field_w($clog2(CXU_N_CXUS));
   localparam int unsigned STATE_W = field_w($clog2(CXU_N_STATES));
   localparam int unsigned FUNC_W  = field_w(CXU_FUNC_ID_W);
   localparam int unsigned INSN_W  = field_w(CXU_INSN_W);
   localparam int unsigned DATA_W  = field_w(CXU_DATA_W);
   localparam int unsigned PAY_W   = ID_W + STATE_W + FUNC_W + INSN_W + 2 * DATA_W;
   localparam int unsigned RESP_W  = CXU_STATUS_W + DATA_W;
   localparam int unsigned OUT_W   = $clog2(N_REQS + 1);
   localparam int unsigned CNT_W   = $clog2(RESP_DEPTH) + 1;

   skid_state_e      state_q;
   logic [PAY_W-1:0] slot0_q;   // head, always the oldest request
   logic [PAY_W-1:0] slot1_q;
   logic             ready_q;
   logic [OUT_W-1:0] outstanding_q;

   logic [PAY_W-1:0]  in_pay;
   logic              accept;
   logic              launch;
   logic              resp_fire;
   logic              resp_pop;
   logic [RESP_W-1:0] fifo_rdata;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CNT_W-1:0]  fifo_count;

   assign in_pay = {i_link.req_cxu, i_link.req_state, i_link.req_func, i_link.req_insn,
                    i_link.req_data0, i_link.req_data1};

   assign accept    = clk_en & i_link.req_valid & ready_q;
   assign launch    = clk_en & t_link.req_valid & t_link.req_ready;
   // A response with nothing outstanding is a protocol error: dropped, never stored.
   assign resp_fire = clk_en & t_link.resp_valid & t_link.resp_ready & (outstanding_q != '0);
   assign resp_pop  = clk_en & i_link.resp_valid & i_link.resp_ready;

   // ready_q tracks "next state is not TWO"; it stays 0 until the first enabled edge after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StEmpty;
         slot0_q <= '0;
         slot1_q <= '0;
         ready_q <= 1'b0;
      end else if (clk_en) begin
         ready_q <= 1'b1;
         unique case (state_q)
            StEmpty: begin
               if (accept) begin
                  slot0_q <= in_pay;
                  state_q <= StOne;
               end
            end
            StOne: begin
               if (accept && !launch) begin
                  slot1_q <= in_pay;
                  state_q <= StTwo;
                  ready_q <= 1'b0;
               end else if (accept) begin
                  slot0_q <= in_pay;
               end else if (launch) begin
                  state_q <= StEmpty;
               end
            end
            StTwo: begin
               if (launch) begin
                  slot0_q <= slot1_q;
                  state_q <= StOne;
               end else begin
                  ready_q <= 1'b0;
               end
            end
            default: state_q <= StEmpty;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outstanding_q <= '0;
      end else if (launch && !resp_fire) begin
         outstanding_q <= outstanding_q + OUT_W'(1);
      end else if (!launch && resp_fire) begin
         outstanding_q <= outstanding_q - OUT_W'(1);
      end
   end

   // Launch only when both the in-flight limit and a reserved FIFO slot allow it.
   assign t_link.req_valid = (state_q != StEmpty) &&
                             (32'(outstanding_q) < N_REQS) &&
                             (32'(outstanding_q) + 32'(fifo_count) < RESP_DEPTH);
   assign {t_link.req_cxu, t_link.req_state, t_link.req_func, t_link.req_insn,
           t_link.req_data0, t_link.req_data1} = slot0_q;
   assign t_link.resp_ready = ~fifo_full;

   assign i_link.req_ready  = ready_q;
   assign i_link.resp_valid = ~fifo_empty;
   assign {i_link.resp_status, i_link.resp_data} = fifo_rdata;

   cxu_link_buffer_resp_fifo #(
      .DEPTH (RESP_DEPTH),
      .W     (RESP_W)
   ) u_resp_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (resp_fire),
      .wdata ({t_link.resp_status, t_link.resp_data}),
      .pop   (resp_pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assert property (@(posedge clk) disable iff (!rst_n)
      !(clk_en && t_link.resp_valid && t_link.resp_ready && (outstanding_q == '0)))
      else $error("cxu_link_buffer: CXU response with no request outstanding, dropped");

endmodule

// File: tb/tb_cxu_link_buffer.sv
module tb_cxu_link_buffer;
   localparam int unsigned N_REQS     = 2;
   localparam int unsigned RESP_DEPTH = 4;
   localparam int unsigned PAY_W      = 71;  // cxu 2, state 1, func 3, insn 1, data0 32, data1 32
   localparam int unsigned RESP_W     = 35;  // status 3, data 32

   logic clk = 1'b0;
   logic rst_n;
   logic clk_en;

   always #5 clk = ~clk;

   cxu_link_buffer_if #(
      .CXU_N_CXUS(4), .CXU_N_STATES(0), .CXU_FUNC_ID_W(3), .CXU_INSN_W(0), .CXU_DATA_W(32)
   ) ilink ();
   cxu_link_buffer_if #(
      .CXU_N_CXUS(4), .CXU_N_STATES(0), .CXU_FUNC_ID_W(3), .CXU_INSN_W(0), .CXU_DATA_W(32)
   ) tlink ();

   cxu_link_buffer #(
      .CXU_N_CXUS    (4),
      .CXU_N_STATES  (0),
      .CXU_FUNC_ID_W (3),
      .CXU_INSN_W    (0),
      .CXU_DATA_W    (32),
      .N_REQS        (N_REQS),
      .RESP_DEPTH    (RESP_DEPTH)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .clk_en (clk_en),
      .i_link (ilink),
      .t_link (tlink)
   );

   wire [PAY_W-1:0]  in_pay = {ilink.req_cxu, ilink.req_state, ilink.req_func, ilink.req_insn,
                               ilink.req_data0, ilink.req_data1};
   wire [PAY_W-1:0]  t_pay  = {tlink.req_cxu, tlink.req_state, tlink.req_func, tlink.req_insn,
                               tlink.req_data0, tlink.req_data1};
   wire [RESP_W-1:0] i_resp = {ilink.resp_status, ilink.resp_data};

   int unsigned n_cmp;
   int unsigned n_err;
   int unsigned req_pct, treq_pct, tresp_pct, rrdy_pct, en_pct;

   // Reference model: requests accepted but not yet launched, responses owed to the mux,
   // responses the CXU still has to return, and two plain counters.
   logic [PAY_W-1:0]  pend_q[$];
   logic [RESP_W-1:0] exp_q[$];
   logic [RESP_W-1:0] cxu_q[$];
   int unsigned       outst;
   int unsigned       rbuf;
   bit                armed;
   bit                hit;
   bit                done;

   // Behaviour of the modelled CXU: status = func ^ 5, data = data0 + data1 + 1.
   function automatic logic [RESP_W-1:0] resp_of(input logic [PAY_W-1:0] p);
      logic [2:0]  st;
      logic [31:0] d;
      st = p[67:65] ^ 3'b101;
      d  = p[63:32] + p[31:0] + 32'd1;
      return {st, d};
   endfunction

   task automatic chk(input string name, input logic [79:0] got, input logic [79:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Stimulus: mux side and CXU side, driven 1 time unit after each rising edge.
   initial forever begin
      @(posedge clk);
      #1;
      clk_en           = ($urandom_range(99) < en_pct);
      ilink.req_valid  = rst_n && ($urandom_range(99) < req_pct);
      ilink.req_cxu    = 2'($urandom);
      ilink.req_state  = 1'($urandom);
      ilink.req_func   = 3'($urandom);
      ilink.req_insn   = 1'($urandom);
      ilink.req_data0  = $urandom;
      ilink.req_data1  = $urandom;
      ilink.resp_ready = ($urandom_range(99) < rrdy_pct);
      tlink.req_ready  = ($urandom_range(99) < treq_pct);
      if (rst_n && cxu_q.size() > 0 && $urandom_range(99) < tresp_pct) begin
         tlink.resp_valid                       = 1'b1;
         {tlink.resp_status, tlink.resp_data} = cxu_q[0];
      end else begin
         tlink.resp_valid  = 1'b0;
         tlink.resp_status = 3'($urandom);
         tlink.resp_data   = $urandom;
      end
   end

   // Monitor: sample on the falling edge, compare, then advance the model for the next edge.
   initial forever begin
      @(negedge clk);
      if (rst_n) begin
         bit acc, lau, rf, pop;
         acc = clk_en && ilink.req_valid && ilink.req_ready;
         lau = clk_en && tlink.req_valid && tlink.req_ready;
         rf  = clk_en && tlink.resp_valid && tlink.resp_ready;
         pop = clk_en && ilink.resp_valid && ilink.resp_ready;

         chk("i_req_ready", ilink.req_ready, armed && pend_q.size() < 2);
         chk("t_req_valid", tlink.req_valid,
             pend_q.size() > 0 && outst < N_REQS && outst + rbuf < RESP_DEPTH);
         chk("i_resp_valid", ilink.resp_valid, rbuf > 0);
         chk("t_resp_ready", tlink.resp_ready, rbuf < RESP_DEPTH);
         if (tlink.req_valid && pend_q.size() > 0) chk("t_req payload", t_pay, pend_q[0]);
         if (pop) begin
            chk("i_resp owed", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) chk("i_resp payload", i_resp, exp_q.pop_front());
         end

         if (lau && pend_q.size() > 0) begin
            void'(pend_q.pop_front());
            cxu_q.push_back(resp_of(t_pay));
            outst++;
         end
         if (rf && outst > 0) begin
            if (cxu_q.size() > 0) void'(cxu_q.pop_front());
            outst--;
            rbuf++;
         end
         if (pop && rbuf > 0) rbuf--;
         if (acc) begin
            pend_q.push_back(in_pay);
            exp_q.push_back(resp_of(in_pay));
         end
         if (clk_en) armed = 1'b1;
      end
   end

   initial begin
      n_cmp = 0;
      n_err = 0;
      outst = 0;
      rbuf  = 0;
      armed = 1'b0;
      req_pct = 70; treq_pct = 60; tresp_pct = 60; rrdy_pct = 60; en_pct = 90;
      clk_en            = 1'b1;
      ilink.req_valid   = 1'b0;
      ilink.req_cxu     = '0;
      ilink.req_state   = '0;
      ilink.req_func    = '0;
      ilink.req_insn    = '0;
      ilink.req_data0   = '0;
      ilink.req_data1   = '0;
      ilink.resp_ready  = 1'b0;
      tlink.req_ready   = 1'b0;
      tlink.resp_valid  = 1'b0;
      tlink.resp_status = '0;
      tlink.resp_data   = '0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      chk("reset i_req_ready", ilink.req_ready, 1'b0);
      chk("reset t_req_valid", tlink.req_valid, 1'b0);
      chk("reset i_resp_valid", ilink.resp_valid, 1'b0);
      chk("reset t_resp_ready", tlink.resp_ready, 1'b1);
      chk("reset t_req payload", t_pay, '0);
      @(posedge clk);
      #2 rst_n = 1'b1;

      repeat (1500) @(posedge clk);
      rrdy_pct = 0;                      // response FIFO fills, credits stop launches
      repeat (60) @(posedge clk);
      rrdy_pct = 100; tresp_pct = 0;     // CXU silent: in-flight limit binds
      repeat (60) @(posedge clk);
      rrdy_pct = 60; tresp_pct = 60;
      repeat (500) @(posedge clk);

      // Steer towards a full skid buffer with a request in flight, then reset mid-transaction.
      req_pct = 90; treq_pct = 30; tresp_pct = 15;
      hit = 1'b0;
      for (int i = 0; i < 500 && !hit; i++) begin
         @(negedge clk);
         #1 hit = (pend_q.size() == 2) && (outst > 0);
      end
      chk("pre-reset occupancy", hit, 1'b1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid reset i_req_ready", ilink.req_ready, 1'b0);
      chk("mid reset t_req_valid", tlink.req_valid, 1'b0);
      chk("mid reset i_resp_valid", ilink.resp_valid, 1'b0);
      chk("mid reset t_resp_ready", tlink.resp_ready, 1'b1);
      chk("mid reset t_req payload", t_pay, '0);
      pend_q.delete();
      exp_q.delete();
      cxu_q.delete();
      outst = 0;
      rbuf  = 0;
      armed = 1'b0;
      req_pct = 70; treq_pct = 60; tresp_pct = 60;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      repeat (500) @(posedge clk);

      req_pct = 0; treq_pct = 100; tresp_pct = 100; rrdy_pct = 100; en_pct = 100;
      done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         #1 done = pend_q.size() == 0 && exp_q.size() == 0 && cxu_q.size() == 0 &&
                   outst == 0 && rbuf == 0;
      end
      chk("drain complete", done, 1'b1);
      repeat (3) @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
